shift_register: RTL and testbench

- Parallel-load / serial-shift register, default 8 bits.
- Supports parallel-in/serial-out (PISO) and serial-in/parallel-out (SIPO) in one datapath.
- Sits between parallel buses and single-wire serial links. Data is transferred MSB-first in both directions.

---
 rtl/shift_register_if.sv | 27 ++
 rtl/shift_register.sv | 51 +++++
 tb/tb_shift_register.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/shift_register_if.sv
// Parallel/serial data bundle for shift_register.
// master drives load/data/serial-in; slave returns register contents and serial-out.
interface shift_register_if #(
  parameter int WIDTH = 8
);
  logic             i_load;
  logic [WIDTH-1:0] i_d;
  logic             i_s;
  logic [WIDTH-1:0] o_q;
  logic             o_s;

  modport master (
    output i_load,
    output i_d,
    output i_s,
    input  o_q,
    input  o_s
  );

  modport slave (
    input  i_load,
    input  i_d,
    input  i_s,
    output o_q,
    output o_s
  );
endinterface

// File: rtl/shift_register.sv
// Parallel-load / serial-shift register, MSB-first in both directions (PISO and SIPO).
// Optional macro SHIFT_REGISTER_HOLD_EN adds i_en; when it is low the register holds its value.
module shift_register #(
  parameter int WIDTH = 8
) (
  input logic             i_clk,
  input logic             i_rst,
`ifdef SHIFT_REGISTER_HOLD_EN
  input logic             i_en,
`endif
  shift_register_if.slave bus
);

  generate
    if (WIDTH < 2) begin : g_width_chk
      $error("shift_register: WIDTH must be at least 2");
    end
  endgenerate

  logic [WIDTH-1:0] r;
  logic [WIDTH-1:0] r_nxt;
  logic             upd;

`ifdef SHIFT_REGISTER_HOLD_EN
  assign upd = i_en;
`else
  assign upd = 1'b1;
`endif

  // Load wins over shift; i_s is ignored in a load cycle.
  always_comb begin
    r_nxt = r;
    if (bus.i_load) begin
      r_nxt = bus.i_d;
    end else begin
      r_nxt = {r[WIDTH-2:0], bus.i_s};
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r <= '0;
    end else if (upd) begin
      r <= r_nxt;
    end
  end

  assign bus.o_q = r;
  assign bus.o_s = r[WIDTH-1];

endmodule

// File: tb/tb_shift_register.sv
// Directed bench for shift_register: reset, PISO, SIPO, load priority, mid-transfer reset,
// a random PISO/SIPO loop, and the i_en hold when SHIFT_REGISTER_HOLD_EN is defined.
module tb_shift_register;
  localparam int W = 8;

  logic i_clk;
  logic i_rst;
`ifdef SHIFT_REGISTER_HOLD_EN
  logic i_en;
`endif

  int total;
  int bad;

  shift_register_if #(.WIDTH(W)) bus ();

  shift_register #(.WIDTH(W)) dut (
    .i_clk (i_clk),
    .i_rst (i_rst),
`ifdef SHIFT_REGISTER_HOLD_EN
    .i_en  (i_en),
`endif
    .bus   (bus.slave)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Advance past one rising edge; outputs are sampled 1 ns later.
  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  // Load w, then shift WIDTH-1 times with i_s=0, checking each serial bit MSB-first.
  task automatic piso(input logic [W-1:0] w, input string tag);
    bus.i_load = 1'b1;
    bus.i_d    = w;
    bus.i_s    = 1'b1;
    tick();
    check_val($sformatf("%s_b7", tag), 32'(bus.o_s), 32'(w[W-1]));
    bus.i_load = 1'b0;
    bus.i_s    = 1'b0;
    for (int k = 1; k < W; k++) begin
      tick();
      check_val($sformatf("%s_b%0d", tag, W-1-k), 32'(bus.o_s), 32'(w[W-1-k]));
    end
  endtask

  // Shift w in MSB-first over WIDTH edges, then check the parallel word.
  task automatic sipo(input logic [W-1:0] w, input string tag);
    bus.i_load = 1'b0;
    bus.i_d    = ~w;
    for (int k = W-1; k >= 0; k--) begin
      bus.i_s = w[k];
      tick();
    end
    check_val(tag, 32'(bus.o_q), 32'(w));
  endtask

  initial begin
    logic [W-1:0] w;
    total = 0;
    bad   = 0;
`ifdef SHIFT_REGISTER_HOLD_EN
    i_en = 1'b1;
`endif
    i_rst      = 1'b1;
    bus.i_load = 1'b1;
    bus.i_d    = 8'hFF;
    bus.i_s    = 1'b1;
    #1;
    check_val("rst_q_init", 32'(bus.o_q), 32'h0);
    for (int c = 0; c < 4; c++) begin
      tick();
      check_val($sformatf("rst_q_c%0d", c), 32'(bus.o_q), 32'h0);
      check_val($sformatf("rst_s_c%0d", c), 32'(bus.o_s), 32'h0);
    end
    i_rst = 1'b0;

    // Asynchronous clear between edges.
    bus.i_load = 1'b1;
    bus.i_d    = 8'hC3;
    tick();
    check_val("async_pre", 32'(bus.o_q), 32'hC3);
    i_rst = 1'b1;
    #2;
    check_val("async_q", 32'(bus.o_q), 32'h0);
    check_val("async_s", 32'(bus.o_s), 32'h0);
    i_rst = 1'b0;

    piso(8'hA5, "piso_a5");
    check_val("piso_a5_q", 32'(bus.o_q), 32'h80);

    sipo(8'h3C, "sipo_3c");
    bus.i_s = 1'b0;
    tick();
    check_val("sipo_extra", 32'(bus.o_q), 32'h78);

    bus.i_load = 1'b1;
    bus.i_d    = 8'h5A;
    bus.i_s    = 1'b1;
    tick();
    check_val("load_prio", 32'(bus.o_q), 32'h5A);

    bus.i_load = 1'b1;
    bus.i_d    = 8'hFF;
    tick();
    bus.i_load = 1'b0;
    bus.i_s    = 1'b0;
    tick();
    tick();
    tick();
    check_val("mid_shift3", 32'(bus.o_q), 32'hF8);
    i_rst = 1'b1;
    #2;
    check_val("mid_rst", 32'(bus.o_q), 32'h0);
    i_rst = 1'b0;
    sipo(8'h81, "mid_sipo_81");

`ifdef SHIFT_REGISTER_HOLD_EN
    // 8'hB2 = 1011_0010; hold after two shifts, with a competing load presented.
    w = 8'hB2;
    bus.i_load = 1'b1;
    bus.i_d    = w;
    tick();
    check_val("hold_b7", 32'(bus.o_s), 32'h1);
    bus.i_load = 1'b0;
    bus.i_s    = 1'b0;
    tick();
    check_val("hold_b6", 32'(bus.o_s), 32'h0);
    tick();
    check_val("hold_b5", 32'(bus.o_s), 32'h1);
    i_en       = 1'b0;
    bus.i_load = 1'b1;
    bus.i_d    = 8'h00;
    for (int c = 0; c < 3; c++) begin
      tick();
      check_val($sformatf("hold_s_c%0d", c), 32'(bus.o_s), 32'h1);
      check_val($sformatf("hold_q_c%0d", c), 32'(bus.o_q), 32'hC8);
    end
    i_en       = 1'b1;
    bus.i_load = 1'b0;
    for (int k = 4; k >= 0; k--) begin
      tick();
      check_val($sformatf("hold_b%0d", k), 32'(bus.o_s), 32'(w[k]));
    end
    i_en  = 1'b0;
    i_rst = 1'b1;
    #2;
    check_val("hold_rst", 32'(bus.o_q), 32'h0);
    i_rst = 1'b0;
    i_en  = 1'b1;
`endif

    for (int it = 0; it < 100; it++) begin
      w = W'($urandom);
      piso(w, $sformatf("rnd%0d_piso", it));
      w = W'($urandom);
      sipo(w, $sformatf("rnd%0d_sipo", it));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
